// File: rtl/vga_sync.sv
// vga_sync: pixel-timing generator for the 640x480@60 Hz display path.
//
// Divides the system clock down to the pixel rate, counts pixel columns and
// lines, and produces the sync/blanking decode aligned with the coordinates.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   xg         out  current pixel column, 0..H_TOTAL-1 (registered)
//   yg         out  current line, 0..V_TOTAL-1 (registered)
//   hsync      out  horizontal sync, active-low (registered)
//   vsync      out  vertical sync, active-low (registered)
//   video_on   out  high while (xg, yg) is in the visible area (registered)
//   p_tick     out  one-clk pulse per pixel period (divider == CLK_DIV-1)
//   frame_tick out  one-clk pulse on the first cycle of each new frame
//
// CLK_DIV must be 1..16 and both H_TOTAL and V_TOTAL must fit in 10 bits.
module vga_sync #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] xg,
  output logic [9:0] yg,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
  localparam logic [9:0] HSyncFirst = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HSyncLast  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncFirst = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VSyncLast  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            hsync_q, vsync_q, video_on_q, frame_tick_q;
  logic            tick;

  // With CLK_DIV=1 the divider is stuck at 0 == DivLast, so tick stays high.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + DivW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Decode uses the next counter values so the registered flags change on the
  // same edge as xg/yg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= !((h_d >= HSyncFirst) && (h_d <= HSyncLast));
      vsync_q      <= !((v_d >= VSyncFirst) && (v_d <= VSyncLast));
      video_on_q   <= (h_d < HDisp) && (v_d < VDisp);
      // Only an actual wrap into (0,0) fires; reset alone never does.
      frame_tick_q <= tick && (h_d == '0) && (v_d == '0);
    end
  end

  assign xg         = h_q;
  assign yg         = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign p_tick     = tick;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync. Three instances share clock and reset:
//   a: default 640x480 timing, CLK_DIV=4
//   b: tiny timing (24x17 totals, CLK_DIV=2) so whole frames fit in the run
//   c: default timing, CLK_DIV=1
// Expected outputs come from a cycle-count model: pixel = t / div, etc.
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic hsa, vsa, vona, pta, fta;
  logic hsb, vsb, vonb, ptb, ftb;
  logic hsc, vsc, vonc, ptc, ftc;

  vga_sync u_a (
    .clk(clk), .rst(rst), .xg(xa), .yg(ya), .hsync(hsa), .vsync(vsa),
    .video_on(vona), .p_tick(pta), .frame_tick(fta)
  );

  vga_sync #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .clk(clk), .rst(rst), .xg(xb), .yg(yb), .hsync(hsb), .vsync(vsb),
    .video_on(vonb), .p_tick(ptb), .frame_tick(ftb)
  );

  vga_sync #(
    .CLK_DIV(1)
  ) u_c (
    .clk(clk), .rst(rst), .xg(xc), .yg(yc), .hsync(hsc), .vsync(vsc),
    .video_on(vonc), .p_tick(ptc), .frame_tick(ftc)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
  } vid_t;

  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  vid_t obs_a, obs_b, obs_c, exp_a, exp_b, exp_c;

  // clk edges seen since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) t <= 0;
    else      t <= t + 1;
  end

  function automatic vid_t model(input int tt, input int div,
                                 input int hd, input int hf, input int hsy, input int hb,
                                 input int vd, input int vf, input int vsy, input int vb);
    vid_t r;
    int ht, vt, p, ph, x, y;
    ht = hd + hf + hsy + hb;
    vt = vd + vf + vsy + vb;
    p  = tt / div;
    ph = tt % div;
    x  = p % ht;
    y  = (p / ht) % vt;
    r.x   = 10'(x);
    r.y   = 10'(y);
    r.hs  = !((x >= hd + hf) && (x < hd + hf + hsy));
    r.vs  = !((y >= vd + vf) && (y < vd + vf + vsy));
    r.von = (x < hd) && (y < vd);
    r.pt  = (ph == div - 1);
    r.ft  = (p > 0) && (p % (ht * vt) == 0) && (ph == 0);
    return r;
  endfunction

  task automatic sample();
    obs_a = {xa, ya, hsa, vsa, vona, pta, fta};
    obs_b = {xb, yb, hsb, vsb, vonb, ptb, ftb};
    obs_c = {xc, yc, hsc, vsc, vonc, ptc, ftc};
    exp_a = model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    exp_b = model(t, 2, 16, 2, 3, 3, 10, 2, 2, 3);
    exp_c = model(t, 1, 640, 16, 96, 48, 480, 10, 2, 33);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    sample();
  endtask

  task automatic test_reset();
    bit found = 1'b0;
    int first_pt = -1;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("FAIL reset_run_a t=%0d got %h exp %h", t, obs_a, exp_a);
      end
      if (obs_a.x == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach_x300 got xg=%0d exp 300", obs_a.x);
    end
    // Mid-line asynchronous reset, checked before any clock edge
    rst = 1'b0;
    #1;
    sample();
    checks++;
    if (obs_a !== {10'd0, 10'd0, 5'b11100}) begin
      errors++;
      $display("FAIL reset_async_a got %h exp %h", obs_a, {10'd0, 10'd0, 5'b11100});
    end
    checks++;
    if (obs_b !== {10'd0, 10'd0, 5'b11100}) begin
      errors++;
      $display("FAIL reset_async_b got %h exp %h", obs_b, {10'd0, 10'd0, 5'b11100});
    end
    checks++;
    if (obs_c !== {10'd0, 10'd0, 5'b11110}) begin
      errors++;
      $display("FAIL reset_async_c got %h exp %h", obs_c, {10'd0, 10'd0, 5'b11110});
    end
    repeat (2) tick();
    checks++;
    if (obs_a !== {10'd0, 10'd0, 5'b11100}) begin
      errors++;
      $display("FAIL reset_held_a got %h exp %h", obs_a, {10'd0, 10'd0, 5'b11100});
    end
    rst = 1'b1;
    sample();
    for (int i = 0; i < 12; i++) begin
      if (obs_a.pt && first_pt < 0) first_pt = t;
      tick();
    end
    checks++;
    if (first_pt != 3) begin
      errors++;
      $display("FAIL reset_first_ptick got cycle %0d exp 3", first_pt);
    end
  endtask

  task automatic test_cadence();
    int run_len = 0;
    logic [9:0] prev_x;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sample();
    prev_x = obs_a.x;
    for (int i = 0; i <= 40; i++) begin
      checks++;
      if (obs_a.pt !== ((t % 4) == 3) || obs_a.x !== 10'(t / 4)) begin
        errors++;
        $display("FAIL cadence t=%0d got pt=%b xg=%0d exp pt=%b xg=%0d",
                 t, obs_a.pt, obs_a.x, (t % 4) == 3, t / 4);
      end
      if (obs_a.x != prev_x) begin
        checks++;
        if (run_len != 4) begin
          errors++;
          $display("FAIL cadence_hold xg=%0d held %0d exp 4", prev_x, run_len);
        end
        run_len = 0;
      end
      prev_x = obs_a.x;
      run_len++;
      if (i < 40) tick();
    end
    checks++;
    if (obs_a.x !== 10'd10) begin
      errors++;
      $display("FAIL cadence_end got xg=%0d exp 10", obs_a.x);
    end
  endtask

  task automatic test_hsync_window();
    bit found = 1'b0;
    int low = 0;
    int fall_x = -1;
    logic prev_von;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick();
      if (obs_a.x == 10'd0 && (t % 4) == 0 && t > 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hsync_line_start got xg=%0d exp 0", obs_a.x);
    end
    prev_von = obs_a.von;
    for (int i = 0; i < 3200; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("FAIL hsync_line_a t=%0d got %h exp %h", t, obs_a, exp_a);
      end
      if (!obs_a.hs) low++;
      if (prev_von && !obs_a.von) fall_x = obs_a.x;
      prev_von = obs_a.von;
    end
    checks++;
    if (low != 384) begin
      errors++;
      $display("FAIL hsync_low_cycles got %0d exp 384", low);
    end
    checks++;
    if (fall_x != 640) begin
      errors++;
      $display("FAIL video_on_fall got xg=%0d exp 640", fall_x);
    end
  endtask

  task automatic test_line_wrap();
    bit found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("FAIL line_run_a t=%0d got %h exp %h", t, obs_a, exp_a);
      end
      if (obs_a.x == 10'd799 && obs_a.y == 10'd5 && obs_a.pt) begin
        found = 1'b1;
        tick();
        checks++;
        if (obs_a.x !== 10'd0 || obs_a.y !== 10'd6 || obs_a.von !== 1'b1) begin
          errors++;
          $display("FAIL line_wrap got xg=%0d yg=%0d von=%b exp 0 6 1",
                   obs_a.x, obs_a.y, obs_a.von);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL line_wrap_reach got yg=%0d exp 5", obs_a.y);
    end
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    int last_ft = -1;
    int vs_low = 0;
    int wraps = 0;
    vid_t prev;
    sample();
    prev = obs_b;
    for (int i = 0; i < 3 * 816; i++) begin
      tick();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL frame_run_b t=%0d got %h exp %h", t, obs_b, exp_b);
      end
      if (!obs_b.vs) vs_low++;
      if (obs_b.ft) begin
        pulses++;
        checks++;
        if (prev.ft) begin
          errors++;
          $display("FAIL frame_tick_width got 2+ cycles exp 1");
        end
        if (last_ft >= 0) begin
          checks++;
          if (t - last_ft != 816) begin
            errors++;
            $display("FAIL frame_period got %0d exp 816", t - last_ft);
          end
        end
        last_ft = t;
      end
      if (prev.x == 10'd23 && prev.y == 10'd16 && prev.pt) begin
        wraps++;
        checks++;
        if (obs_b.x !== 10'd0 || obs_b.y !== 10'd0 || obs_b.ft !== 1'b1) begin
          errors++;
          $display("FAIL frame_wrap got xg=%0d yg=%0d ft=%b exp 0 0 1",
                   obs_b.x, obs_b.y, obs_b.ft);
        end
      end
      prev = obs_b;
    end
    checks++;
    if (pulses != 3 || wraps != 3) begin
      errors++;
      $display("FAIL frame_pulses got %0d/%0d exp 3/3", pulses, wraps);
    end
    checks++;
    if (vs_low != 288) begin
      errors++;
      $display("FAIL vsync_low_cycles got %0d exp 288", vs_low);
    end
  endtask

  task automatic test_clkdiv1();
    int last_zero = -1;
    logic [9:0] prev_x;
    sample();
    prev_x = obs_c.x;
    for (int i = 0; i < 1700; i++) begin
      tick();
      checks++;
      if (obs_c !== exp_c || obs_c.pt !== 1'b1) begin
        errors++;
        $display("FAIL div1_run_c t=%0d got %h exp %h", t, obs_c, exp_c);
      end
      checks++;
      if (obs_c.x !== ((prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1)) begin
        errors++;
        $display("FAIL div1_step got xg=%0d after %0d", obs_c.x, prev_x);
      end
      if (obs_c.x == 10'd0) begin
        if (last_zero >= 0) begin
          checks++;
          if (t - last_zero != 800) begin
            errors++;
            $display("FAIL div1_line_period got %0d exp 800", t - last_zero);
          end
        end
        last_zero = t;
      end
      prev_x = obs_c.x;
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(600, 20);
      for (int i = 0; i < n; i++) begin
        tick();
        checks++;
        if (obs_a !== exp_a || obs_b !== exp_b || obs_c !== exp_c) begin
          errors++;
          $display("FAIL rand_run it=%0d t=%0d got %h/%h/%h exp %h/%h/%h",
                   it, t, obs_a, obs_b, obs_c, exp_a, exp_b, exp_c);
        end
      end
      #($urandom_range(2, 0));
      rst = 1'b0;
      #1;
      sample();
      checks++;
      if (obs_a !== {10'd0, 10'd0, 5'b11100} || obs_b !== {10'd0, 10'd0, 5'b11100} ||
          obs_c !== {10'd0, 10'd0, 5'b11110}) begin
        errors++;
        $display("FAIL rand_reset it=%0d got %h/%h/%h", it, obs_a, obs_b, obs_c);
      end
      repeat ($urandom_range(3, 0)) tick();
      rst = 1'b1;
      sample();
      checks++;
      if (obs_a !== exp_a || obs_b !== exp_b || obs_c !== exp_c) begin
        errors++;
        $display("FAIL rand_release it=%0d got %h/%h/%h exp %h/%h/%h",
                 it, obs_a, obs_b, obs_c, exp_a, exp_b, exp_c);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout sim time %0t exp finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_cadence();
    test_hsync_window();
    test_line_wrap();
    test_frame_wrap();
    test_clkdiv1();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
